lfo_scheduler: RTL and testbench

- Time-multiplexes one shared sine ROM (12-bit address, 16-bit signed data, 1-cycle read latency) across N_CH low-frequency oscillators: auto-pan, tremolo, vibrato and similar modulation sources.
- On each sample strobe it steps every channel's phase accumulator, fetches that channel's sine sample and depth-scales it around centre 16'h4000.
- It then publishes all channel outputs together as one coherent set.
- Replaces per-effect integrator/ROM pairs with one scheduled resource.

---
 rtl/lfo_pkg.sv | 16 +
 rtl/lfo_scale.sv | 23 ++
 rtl/lfo_scheduler.sv | 120 ++++++++++++
 tb/tb_lfo_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO scheduler and the depth-scaling helper.
package lfo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CALC,
        DONE
    } lfo_state_t;

    localparam logic [15:0] CENTER = 16'h4000;
    localparam int          ROM_AW = 12;
    localparam int          DW     = 16;

endpackage

// File: rtl/lfo_scale.sv
// Depth scaling of one sine sample around the modulation centre.
// The sample is halved before the multiply so that the full-scale product
// lands within +/-quarter range of the 16-bit output once the top half is taken.
module lfo_scale import lfo_pkg::*; #(
    parameter logic [DW-1:0] OFFSET = CENTER
) (
    input  logic [DW-1:0] depth,
    input  logic [DW-1:0] sample,
    input  logic          en,
    output logic [DW-1:0] scaled
);

    logic signed [DW-1:0]   half;
    logic signed [2*DW-1:0] prod;

    // Signed multiply, keep the top half, add the centre with plain 16-bit wrap
    always_comb begin
        half   = $signed(sample) >>> 1;
        prod   = $signed(depth) * half;
        scaled = en ? (prod[2*DW-1:DW] + OFFSET) : OFFSET;
    end

endmodule

// File: rtl/lfo_scheduler.sv
// Time-multiplexed LFO bank: one shared sine ROM serves N_CH phase accumulators.
// Each sample tick runs a scan of ADDR/WAIT/CALC per channel, then publishes
// every lane at once in DONE so consumers always see a coherent set.
module lfo_scheduler #(
    parameter int          N_CH   = 4,
    parameter int          ACC_W  = 24,
    parameter logic [15:0] CENTER = 16'h4000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              SAMPLE_TICK,
    input  logic [N_CH-1:0]   EN,
    input  logic [N_CH*16-1:0] FREQ,
    input  logic [N_CH*16-1:0] DEPTH,
    output logic              ROM_CS,
    output logic [11:0]       ROM_ADDR,
    input  logic [15:0]       ROM_DATA,
    output logic [N_CH*16-1:0] LFO_OUT,
    output logic              OUT_VALID,
    output logic              BUSY,
    output logic              OVERRUN
);
    import lfo_pkg::*;

    localparam int                CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]   LAST = CH_W'(N_CH - 1);

    lfo_state_t        state;
    logic [CH_W-1:0]   ch;

    // Shadow copies of the per-channel controls, frozen for the whole scan
    logic              en_sh    [N_CH];
    logic [DW-1:0]     freq_sh  [N_CH];
    logic [DW-1:0]     depth_sh [N_CH];
    logic [DW-1:0]     shadow_out [N_CH];
    logic [ACC_W-1:0]  phase    [N_CH];

    logic [ACC_W-1:0]  next_phase;
    logic [DW-1:0]     scaled;

    // Post-increment phase of the channel being addressed; disabled channels restart at 0
    always_comb begin
        next_phase = en_sh[ch] ? (phase[ch] + ACC_W'(freq_sh[ch])) : '0;
    end

    lfo_scale #(
        .OFFSET (CENTER)
    ) u_scale (
        .depth  (depth_sh[ch]),
        .sample (ROM_DATA),
        .en     (en_sh[ch]),
        .scaled (scaled)
    );

    // Scan sequencer: shadow capture, ROM access, scaling and coherent publish
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= IDLE;
            ch        <= '0;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
            ROM_CS    <= 1'b0;
            ROM_ADDR  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                phase[c]            <= '0;
                LFO_OUT[c*DW +: DW] <= CENTER;
            end
        end else begin
            OUT_VALID <= 1'b0;
            // A tick that cannot start a scan is dropped and remembered
            if (SAMPLE_TICK && (state != IDLE)) begin
                OVERRUN <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (SAMPLE_TICK) begin
                        for (int c = 0; c < N_CH; c++) begin
                            en_sh[c]    <= EN[c];
                            freq_sh[c]  <= FREQ[c*DW +: DW];
                            depth_sh[c] <= DEPTH[c*DW +: DW];
                        end
                        ch    <= '0;
                        BUSY  <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    phase[ch] <= next_phase;
                    ROM_CS    <= 1'b1;
                    ROM_ADDR  <= next_phase[ACC_W-1 -: ROM_AW];
                    state     <= WAIT;
                end
                WAIT: begin
                    ROM_CS <= 1'b0;
                    state  <= CALC;
                end
                CALC: begin
                    shadow_out[ch] <= scaled;
                    if (ch == LAST) begin
                        state <= DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ADDR;
                    end
                end
                DONE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        LFO_OUT[c*DW +: DW] <= shadow_out[c];
                    end
                    OUT_VALID <= 1'b1;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfo_scheduler.sv
// Directed bench for lfo_scheduler with a synchronous ROM model and a
// scoreboard of expected ROM addresses and published LFO vectors.
module tb_lfo_scheduler;

    localparam int N_CH  = 4;
    localparam int ACC_W = 24;

    logic               CLOCK_50 = 1'b0;
    logic               RESET;
    logic               SAMPLE_TICK;
    logic [N_CH-1:0]    EN;
    logic [N_CH*16-1:0] FREQ;
    logic [N_CH*16-1:0] DEPTH;
    logic               ROM_CS;
    logic [11:0]        ROM_ADDR;
    logic [15:0]        ROM_DATA = 16'h0000;
    logic [N_CH*16-1:0] LFO_OUT;
    logic               OUT_VALID;
    logic               BUSY;
    logic               OVERRUN;

    always #5 CLOCK_50 = ~CLOCK_50;

    lfo_scheduler #(
        .N_CH   (N_CH),
        .ACC_W  (ACC_W),
        .CENTER (16'h4000)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .SAMPLE_TICK (SAMPLE_TICK),
        .EN          (EN),
        .FREQ        (FREQ),
        .DEPTH       (DEPTH),
        .ROM_CS      (ROM_CS),
        .ROM_ADDR    (ROM_ADDR),
        .ROM_DATA    (ROM_DATA),
        .LFO_OUT     (LFO_OUT),
        .OUT_VALID   (OUT_VALID),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN)
    );

    int tests = 0;
    int fails = 0;

    // ROM model: either a constant or an address-dependent pattern
    logic        rom_const_mode = 1'b1;
    logic [15:0] rom_const      = 16'h0000;

    function automatic logic [15:0] rom_fn(input logic [11:0] a);
        if (rom_const_mode) return rom_const;
        return {a[7:0], a[11:4]} ^ 16'h5A3C;
    endfunction

    always @(posedge CLOCK_50) begin
        if (ROM_CS) ROM_DATA <= rom_fn(ROM_ADDR);
    end

    // Reference model state and scoreboard
    logic [ACC_W-1:0]   m_phase [N_CH];
    logic [11:0]        addr_q[$];
    logic [N_CH*16-1:0] out_q[$];
    logic [11:0]        last_addr0;

    function automatic logic [15:0] scale_ref(input logic [15:0] d, input logic [15:0] s, input logic en);
        logic signed [31:0] p;
        logic signed [15:0] h;
        h = $signed(s) >>> 1;
        p = $signed(d) * h;
        return en ? (p[31:16] + 16'h4000) : 16'h4000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) m_phase[c] = '0;
        addr_q.delete();
        out_q.delete();
    endtask

    task automatic push_scan();
        logic [N_CH*16-1:0] exp_out;
        logic [11:0]        a;
        for (int c = 0; c < N_CH; c++) begin
            m_phase[c] = EN[c] ? (m_phase[c] + {8'h00, FREQ[c*16 +: 16]}) : '0;
            a = m_phase[c][ACC_W-1 -: 12];
            addr_q.push_back(a);
            exp_out[c*16 +: 16] = scale_ref(DEPTH[c*16 +: 16], rom_fn(a), EN[c]);
        end
        out_q.push_back(exp_out);
    endtask

    // One tick and its scan; optional second tick at cycle extra_at,
    // optional reset at cycle abort_at, optional input scramble mid-scan.
    task automatic run_scan(input int extra_at, input int abort_at, input bit scramble);
        int cyc;
        int idx;
        bit done;
        logic [11:0] a;
        @(negedge CLOCK_50);
        SAMPLE_TICK = 1'b1;
        push_scan();
        @(negedge CLOCK_50);
        SAMPLE_TICK = 1'b0;
        cyc  = 0;
        idx  = 0;
        done = 1'b0;
        check("busy_after_tick", BUSY, 1'b1);
        while (!done && cyc < 40) begin
            @(negedge CLOCK_50);
            cyc++;
            SAMPLE_TICK = (extra_at > 0) && (cyc == extra_at - 1);
            if (scramble && cyc == 2) begin
                EN    = N_CH'($urandom);
                FREQ  = {$urandom, $urandom};
                DEPTH = {$urandom, $urandom};
            end
            if (abort_at > 0 && cyc == abort_at) RESET = 1'b1;
            if (abort_at > 0 && cyc == abort_at + 1) begin
                RESET = 1'b0;
                done  = 1'b1;
            end
            if (ROM_CS) begin
                if (addr_q.size() == 0) begin
                    check("rom_cs_extra", ROM_CS, 1'b0);
                end else begin
                    a = addr_q.pop_front();
                    if (idx == 0) last_addr0 = ROM_ADDR;
                    check("rom_addr", ROM_ADDR, a);
                    check("rom_cs_cycle", cyc, 3 * idx + 1);
                    idx++;
                end
            end
            if (OUT_VALID) begin
                check("valid_latency", cyc, 3 * N_CH + 1);
                if (out_q.size() == 0) check("valid_unexpected", OUT_VALID, 1'b0);
                else check("lfo_out", LFO_OUT, out_q.pop_front());
                done = 1'b1;
            end
        end
        if (!done) check("scan_timeout", cyc, 3 * N_CH + 1);
        if (abort_at == 0) check("rom_cs_count", idx, N_CH);
    endtask

    // Idle for n cycles, counting ROM_CS and OUT_VALID pulses and BUSY highs
    task automatic idle_watch(input int n, output int cs_n, output int vld_n, output int busy_n);
        cs_n = 0; vld_n = 0; busy_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            if (ROM_CS) cs_n++;
            if (OUT_VALID) vld_n++;
            if (BUSY) busy_n++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        model_clear();
    endtask

    initial begin
        int cs_n, vld_n, busy_n;
        RESET       = 1'b1;
        SAMPLE_TICK = 1'b0;
        EN          = '0;
        FREQ        = '0;
        DEPTH       = '0;
        last_addr0  = '0;
        model_clear();
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;

        // Reset state and idle behaviour
        check("rst_lfo_out", LFO_OUT, {N_CH{16'h4000}});
        check("rst_busy", BUSY, 1'b0);
        check("rst_overrun", OVERRUN, 1'b0);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_rom_cs", ROM_CS, 1'b0);
        check("rst_rom_addr", ROM_ADDR, 12'h000);
        idle_watch(20, cs_n, vld_n, busy_n);
        check("idle_rom_cs", cs_n, 0);
        check("idle_busy", busy_n, 0);
        check("idle_valid", vld_n, 0);
        check("idle_lfo_out", LFO_OUT, {N_CH{16'h4000}});

        // Single channel, full-scale positive sample
        EN        = 4'b0001;
        FREQ      = {48'h0, 16'h1000};
        DEPTH     = {48'h0, 16'h7FFF};
        rom_const = 16'h7FFF;
        run_scan(0, 0, 1'b0);
        check("first_addr", last_addr0, 12'h001);
        check("lane0_pos", LFO_OUT[15:0], 16'h5FFF);
        check("lanes_disabled", LFO_OUT[63:16], {3{16'h4000}});
        @(negedge CLOCK_50);
        check("valid_one_cycle", OUT_VALID, 1'b0);
        check("busy_released", BUSY, 1'b0);

        // Full-scale negative sample
        rom_const = 16'h8000;
        run_scan(0, 0, 1'b0);
        check("lane0_neg", LFO_OUT[15:0], 16'h2000);
        check("lanes_disabled2", LFO_OUT[63:16], {3{16'h4000}});

        // Mixed channels with patterned ROM; inputs scrambled mid-scan
        rom_const_mode = 1'b0;
        EN    = 4'b1011;
        FREQ  = {16'h0123, 16'hFFFF, 16'h8001, 16'h1000};
        DEPTH = {16'h8000, 16'h4000, 16'hC001, 16'h7FFF};
        run_scan(0, 0, 1'b1);
        EN    = 4'b1111;
        FREQ  = {16'hF00D, 16'h0040, 16'h7777, 16'h2345};
        DEPTH = {16'h7FFF, 16'hFFFF, 16'h8001, 16'h1234};
        run_scan(0, 0, 1'b0);
        run_scan(0, 0, 1'b0);

        // Phase wrap over 4096 ticks
        do_reset();
        EN    = 4'b0001;
        FREQ  = {48'h0, 16'h1000};
        DEPTH = {48'h0, 16'h7FFF};
        for (int t = 0; t < 4096; t++) run_scan(0, 0, 1'b0);
        check("wrap_addr", last_addr0, 12'h000);
        check("wrap_no_overrun", OVERRUN, 1'b0);

        // Tick while busy, mid-scan and in the DONE cycle
        run_scan(5, 0, 1'b0);
        check("overrun_set", OVERRUN, 1'b1);
        idle_watch(20, cs_n, vld_n, busy_n);
        check("overrun_single_valid", vld_n, 0);
        check("overrun_no_rescan", cs_n, 0);
        run_scan(13, 0, 1'b0);
        idle_watch(20, cs_n, vld_n, busy_n);
        check("done_tick_dropped", vld_n, 0);
        run_scan(0, 0, 1'b0);
        check("overrun_sticky", OVERRUN, 1'b1);

        // Reset during CALC of channel 2
        EN    = 4'b0111;
        FREQ  = {16'h0, 16'h0500, 16'h0900, 16'h3000};
        DEPTH = {16'h0, 16'h2000, 16'h6000, 16'h7FFF};
        run_scan(0, 8, 1'b0);
        model_clear();
        check("abort_busy", BUSY, 1'b0);
        check("abort_overrun", OVERRUN, 1'b0);
        check("abort_lfo_out", LFO_OUT, {N_CH{16'h4000}});
        idle_watch(20, cs_n, vld_n, busy_n);
        check("abort_no_valid", vld_n, 0);
        check("abort_no_rom_cs", cs_n, 0);
        run_scan(0, 0, 1'b0);
        check("abort_restart_addr", last_addr0, 12'h003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
